// File: rtl/psram_pkg.sv
// Shared definitions for the QPI PSRAM driver and its two-port arbiter:
// sizes, arbiter FSM encoding, port identifiers, error fill and command opcodes.
package psram_pkg;

    localparam int PSRAM_ADDR_W = 24;
    localparam int PSRAM_DATA_W = 16;

    // Returned to the winner when a transaction is abandoned by the watchdog.
    localparam logic [PSRAM_DATA_W-1:0] PSRAM_ERR_FILL = 16'hDEAD;

    localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
    localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;
    localparam logic [7:0] CMD_ENTER_QPI  = 8'h35;
    localparam logic [7:0] CMD_RESET_EN   = 8'h66;
    localparam logic [7:0] CMD_RESET      = 8'h99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: combinational winner plus the last-grant register,
// which only moves when the caller commits the pick with take.
module rr_arb2
    import psram_pkg::*;
(
    input  logic mem_clk,
    input  logic rst,
    input  logic a_req,
    input  logic b_req,
    input  logic take,
    output logic valid,
    output logic pick
);

    port_e last_grant;

    assign valid = a_req | b_req;

    always_comb begin
        pick = PORT_A;
        if (a_req && b_req) begin
            pick = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req) begin
            pick = PORT_B;
        end
    end

    // Starting from B means A wins the first tie after reset.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            last_grant <= PORT_B;
        end else if (take) begin
            last_grant <= port_e'(pick);
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the QPI PSRAM driver.
// Define PSRAM_ARB_TIMEOUT_EN to add the WAIT watchdog and the sticky err flag.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    mem_clk,
    input  logic                    rst,
    input  logic                    qpi_on,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [PSRAM_ADDR_W-1:0] a_addr,
    input  logic [PSRAM_DATA_W-1:0] a_wdata,
    output logic                    a_ack,
    output logic [PSRAM_DATA_W-1:0] a_rdata,
    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [PSRAM_ADDR_W-1:0] b_addr,
    input  logic [PSRAM_DATA_W-1:0] b_wdata,
    output logic                    b_ack,
    output logic [PSRAM_DATA_W-1:0] b_rdata,
    output logic                    read_sw,
    output logic                    write_sw,
    output logic [PSRAM_ADDR_W-1:0] address,
    output logic [PSRAM_DATA_W-1:0] data_in,
    input  logic [PSRAM_DATA_W-1:0] data_out,
    input  logic                    psram_done,
    output logic                    busy,
    output logic                    err
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("psram_arbiter: GAP_CYCLES must be 1..15 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e              state, state_d;
    logic [3:0]              gap_cnt;
    logic                    we_q;
    logic                    owner_b;
    logic                    arb_valid;
    logic                    arb_pick;
    logic                    grant;
    logic                    timeout_hit;
    logic                    done_hit;
    logic [PSRAM_DATA_W-1:0] rd_val;

    assign grant    = (state == ST_IDLE) && qpi_on && arb_valid;
    assign done_hit = (state == ST_WAIT) && (psram_done || timeout_hit);
    assign rd_val   = timeout_hit ? PSRAM_ERR_FILL : data_out;
    assign busy     = (state != ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .mem_clk (mem_clk),
        .rst     (rst),
        .a_req   (a_req),
        .b_req   (b_req),
        .take    (grant),
        .valid   (arb_valid),
        .pick    (arb_pick)
    );

`ifdef PSRAM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // A done pulse on the final cycle still wins over the watchdog.
    assign timeout_hit = (state == ST_WAIT) && !psram_done
                         && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign err = err_q;

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == ST_WAIT) ? to_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:  if (grant) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done_hit) state_d = ST_GAP;
            ST_GAP:   if (gap_cnt == 4'd0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            read_sw  <= 1'b0;
            write_sw <= 1'b0;
            address  <= '0;
            data_in  <= '0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            we_q     <= 1'b0;
            owner_b  <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;

            if (grant) begin
                owner_b <= arb_pick;
                we_q    <= arb_pick ? b_we    : a_we;
                address <= arb_pick ? b_addr  : a_addr;
                data_in <= arb_pick ? b_wdata : a_wdata;
            end

            if (state == ST_ISSUE) begin
                read_sw  <= !we_q;
                write_sw <= we_q;
            end

            if (done_hit) begin
                read_sw  <= 1'b0;
                write_sw <= 1'b0;
                a_ack    <= !owner_b;
                b_ack    <= owner_b;
                gap_cnt  <= 4'(GAP_CYCLES - 1);
                // Writes keep the old rdata unless the watchdog aborted them.
                if (!we_q || timeout_hit) begin
                    if (owner_b) begin
                        b_rdata <= rd_val;
                    end else begin
                        a_rdata <= rd_val;
                    end
                end
            end else if (state == ST_GAP && gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: driver model with a small memory,
// expected transactions queued at drive time and compared on each ack.
module tb_psram_arbiter;
    import psram_pkg::*;

    localparam int GAP     = 4;
    localparam int TO      = 20;
    localparam int DRV_DLY = 12;

    logic        mem_clk = 1'b0;
    logic        rst = 1'b1;
    logic        qpi_on = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [23:0] a_addr = '0;
    logic [15:0] a_wdata = '0;
    logic        a_ack;
    logic [15:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [23:0] b_addr = '0;
    logic [15:0] b_wdata = '0;
    logic        b_ack;
    logic [15:0] b_rdata;
    logic        read_sw, write_sw;
    logic [23:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out = 16'h5A5A;
    logic        psram_done = 1'b0;
    logic        busy, err;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        bit          port_b;
        bit          we;
        logic [23:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t        sb[$];
    logic [15:0] ref_mem[bit [23:0]];
    logic [15:0] drv_mem[bit [23:0]];

    psram_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .mem_clk(mem_clk), .rst(rst), .qpi_on(qpi_on),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .read_sw(read_sw), .write_sw(write_sw), .address(address),
        .data_in(data_in), .data_out(data_out), .psram_done(psram_done),
        .busy(busy), .err(err)
    );

    always #5 mem_clk = ~mem_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required summary before it");
        $fatal(1, "time limit");
    end

    // Driver model: done pulses once the strobe has been high DRV_DLY+1 cycles.
    bit drv_hang = 1'b0;
    int strobe_cnt = 0;
    always @(posedge mem_clk) begin
        #1;
        if (read_sw || write_sw) strobe_cnt++;
        else strobe_cnt = 0;
        psram_done = 1'b0;
        data_out   = 16'h5A5A;
        if (!drv_hang && strobe_cnt == DRV_DLY + 1) begin
            psram_done = 1'b1;
            if (write_sw) drv_mem[address] = data_in;
            data_out = drv_mem.exists(address) ? drv_mem[address] : 16'h0000;
        end
    end

    int both_hi = 0;
    int min_gap = 1000;
    int low_run = 0;
    bit had_txn = 1'b0;
    bit prev_hi = 1'b0;
    always @(negedge mem_clk) begin
        if (read_sw && write_sw) both_hi++;
        if (read_sw || write_sw) begin
            if (!prev_hi && had_txn && low_run < min_gap) min_gap = low_run;
            prev_hi = 1'b1;
            had_txn = 1'b1;
            low_run = 0;
        end else begin
            prev_hi = 1'b0;
            low_run++;
        end
    end

    function automatic txn_t make_txn(bit pb, bit we, bit [23:0] addr, logic [15:0] wd);
        txn_t t;
        t.port_b = pb;
        t.we     = we;
        t.addr   = addr;
        if (we) begin
            t.data = wd;
            ref_mem[addr] = wd;
        end else begin
            t.data = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0000;
        end
        return t;
    endfunction

    task automatic drive(input txn_t t);
        if (t.port_b) begin
            b_req = 1'b1; b_we = t.we; b_addr = t.addr; b_wdata = t.we ? t.data : 16'h0;
        end else begin
            a_req = 1'b1; a_we = t.we; a_addr = t.addr; a_wdata = t.we ? t.data : 16'h0;
        end
    endtask

    task automatic wait_ack(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge mem_clk);
            if (a_ack || b_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge mem_clk);
            if (!busy) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        qpi_on = 1'b0;
        repeat (3) @(negedge mem_clk);
        n_total++;
        if ({read_sw, write_sw, a_ack, b_ack, busy, err} !== 6'b0)
            $display("FAIL reset_ctrl: got %b required 000000", {read_sw, write_sw, a_ack, b_ack, busy, err});
        else n_pass++;
        n_total++;
        if ({address, data_in, a_rdata, b_rdata} !== 72'h0)
            $display("FAIL reset_data: got %h required 0", {address, data_in, a_rdata, b_rdata});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_qpi_gate();
        txn_t t;
        txn_t e;
        int   seen;
        bit   got;
        t = make_txn(1'b0, 1'b0, 24'h000123, 16'h0);
        drive(t);
        seen = 0;
        repeat (50) begin
            @(negedge mem_clk);
            if (read_sw || write_sw || a_ack || b_ack || busy) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL qpi_gate: active cycles %0d required 0", seen);
        else n_pass++;
        qpi_on = 1'b1;
        sb.push_back(t);
        @(negedge mem_clk);
        n_total++;
        if ({busy, read_sw} !== 2'b10) $display("FAIL qpi_grant: busy,read_sw %b required 10", {busy, read_sw});
        else n_pass++;
        @(negedge mem_clk);
        n_total++;
        if ({read_sw, write_sw} !== 2'b10) $display("FAIL qpi_strobe: read_sw,write_sw %b required 10", {read_sw, write_sw});
        else n_pass++;
        wait_ack(100, got);
        n_total++;
        if (got !== 1'b1) $display("FAIL qpi_ack: no ack within 100 cycles");
        else n_pass++;
        a_req = 1'b0;
        e = sb.pop_front();
        n_total++;
        if ({a_ack, b_ack, a_rdata} !== {2'b10, e.data})
            $display("FAIL qpi_rdata: ack,rdata %b %h required 10 %h", {a_ack, b_ack}, a_rdata, e.data);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_write();
        txn_t t;
        txn_t e;
        int   hi;
        int   bsy;
        int   extra;
        bit   unstable;
        bit   got;
        t = make_txn(1'b0, 1'b1, 24'h000123, 16'hBEEF);
        sb.push_back(t);
        drive(t);
        hi = 0; unstable = 1'b0; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge mem_clk);
            if (write_sw) begin
                hi++;
                if (address !== t.addr || data_in !== t.data) unstable = 1'b1;
            end
            if (read_sw) unstable = 1'b1;
            if (a_ack || b_ack) begin
                got = 1'b1;
                break;
            end
        end
        a_req = 1'b0;
        e = sb.pop_front();
        n_total++;
        if (got !== 1'b1) $display("FAIL wr_ack: no ack within 200 cycles");
        else n_pass++;
        n_total++;
        if (hi !== DRV_DLY + 1) $display("FAIL wr_strobe_len: write_sw high %0d cycles required %0d", hi, DRV_DLY + 1);
        else n_pass++;
        n_total++;
        if (unstable !== 1'b0) $display("FAIL wr_stable: address/data_in moved or read_sw rose");
        else n_pass++;
        n_total++;
        if ({a_ack, b_ack, write_sw, address, data_in} !== {3'b100, e.addr, e.data})
            $display("FAIL wr_ack_cycle: got %b %h %h required 100 %h %h",
                     {a_ack, b_ack, write_sw}, address, data_in, e.addr, e.data);
        else n_pass++;
        bsy = 0; extra = 0;
        for (int i = 0; i < 50 && busy; i++) begin
            if (!read_sw && !write_sw) bsy++;
            if (i > 0 && (a_ack || b_ack)) extra++;
            @(negedge mem_clk);
        end
        n_total++;
        if (extra !== 0) $display("FAIL wr_ack_width: extra ack cycles %0d required 0", extra);
        else n_pass++;
        n_total++;
        if (bsy !== GAP) $display("FAIL wr_gap: gap cycles %0d required %0d", bsy, GAP);
        else n_pass++;
    endtask

    task automatic test_read();
        txn_t t;
        txn_t e;
        bit   got;
        t = make_txn(1'b0, 1'b0, 24'h000123, 16'h0);
        sb.push_back(t);
        drive(t);
        wait_ack(100, got);
        a_req = 1'b0;
        e = sb.pop_front();
        n_total++;
        if (got !== 1'b1) $display("FAIL rd_ack: no ack within 100 cycles");
        else n_pass++;
        n_total++;
        if ({a_ack, b_ack, a_rdata} !== {2'b10, e.data})
            $display("FAIL rd_a_rdata: ack %b rdata %h required 10 %h", {a_ack, b_ack}, a_rdata, e.data);
        else n_pass++;
        // Port B has not completed any transaction since reset.
        n_total++;
        if (b_rdata !== 16'h0000) $display("FAIL rd_b_untouched: b_rdata %h required 0000", b_rdata);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_round_robin();
        txn_t list[6];
        txn_t e;
        int   ai;
        int   bi;
        int   acks;
        rst = 1'b1;
        repeat (2) @(negedge mem_clk);
        rst = 1'b0;
        sb.delete();
        list[0] = make_txn(1'b0, 1'b1, 24'h000010, 16'h1111);
        list[1] = make_txn(1'b1, 1'b1, 24'h000020, 16'h2222);
        list[2] = make_txn(1'b0, 1'b0, 24'h000020, 16'h0);
        list[3] = make_txn(1'b1, 1'b0, 24'h000010, 16'h0);
        list[4] = make_txn(1'b0, 1'b1, 24'h000030, 16'h3333);
        list[5] = make_txn(1'b1, 1'b0, 24'h000030, 16'h0);
        for (int i = 0; i < 6; i++) sb.push_back(list[i]);
        had_txn = 1'b0; min_gap = 1000; both_hi = 0;
        drive(list[0]);
        drive(list[1]);
        ai = 2; bi = 3; acks = 0;
        for (int i = 0; i < 2000 && acks < 6; i++) begin
            @(negedge mem_clk);
            if (a_ack || b_ack) begin
                e = sb.pop_front();
                acks++;
                n_total++;
                if ({a_ack, b_ack} !== (e.port_b ? 2'b01 : 2'b10))
                    $display("FAIL rr_order[%0d]: ack a,b %b required %b", acks, {a_ack, b_ack}, e.port_b ? 2'b01 : 2'b10);
                else n_pass++;
                n_total++;
                if (address !== e.addr) $display("FAIL rr_addr[%0d]: %h required %h", acks, address, e.addr);
                else n_pass++;
                n_total++;
                if (e.we ? (data_in !== e.data) : ((e.port_b ? b_rdata : a_rdata) !== e.data))
                    $display("FAIL rr_data[%0d]: wdata %h a_rdata %h b_rdata %h required %h",
                             acks, data_in, a_rdata, b_rdata, e.data);
                else n_pass++;
                if (a_ack) begin
                    if (ai < 6) begin drive(list[ai]); ai += 2; end
                    else a_req = 1'b0;
                end
                if (b_ack) begin
                    if (bi < 6) begin drive(list[bi]); bi += 2; end
                    else b_req = 1'b0;
                end
            end
        end
        n_total++;
        if (acks !== 6) $display("FAIL rr_count: acks %0d required 6", acks);
        else n_pass++;
        n_total++;
        if (min_gap < GAP) $display("FAIL rr_gap: min strobe-low gap %0d required >= %0d", min_gap, GAP);
        else n_pass++;
        n_total++;
        if (both_hi !== 0) $display("FAIL rr_exclusive: both strobes high %0d cycles required 0", both_hi);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        txn_t ta;
        txn_t tb;
        txn_t e;
        bit   got;
        sb.delete();
        ta = make_txn(1'b0, 1'b0, 24'h000010, 16'h0);
        drive(ta);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge mem_clk);
            if (read_sw) begin got = 1'b1; break; end
        end
        repeat (3) @(negedge mem_clk);
        n_total++;
        if ({got, read_sw} !== 2'b11) $display("FAIL rm_in_wait: rose,read_sw %b required 11", {got, read_sw});
        else n_pass++;
        // A was granted last; reset must hand the next tie back to A.
        rst = 1'b1;
        tb = make_txn(1'b1, 1'b0, 24'h000030, 16'h0);
        drive(tb);
        sb.push_back(ta);
        sb.push_back(tb);
        @(negedge mem_clk);
        n_total++;
        if ({read_sw, write_sw, busy, a_ack, b_ack} !== 5'b0)
            $display("FAIL rm_abort: strobes,busy,acks %b required 00000", {read_sw, write_sw, busy, a_ack, b_ack});
        else n_pass++;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_ack(100, got);
            e = sb.pop_front();
            n_total++;
            if (got !== 1'b1 || {a_ack, b_ack} !== (e.port_b ? 2'b01 : 2'b10) || (e.port_b ? b_rdata : a_rdata) !== e.data)
                $display("FAIL rm_tie[%0d]: got %b ack %b a_rdata %h b_rdata %h required port_b=%0d data %h",
                         k, got, {a_ack, b_ack}, a_rdata, b_rdata, e.port_b, e.data);
            else n_pass++;
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
        end
        wait_idle();
        rst = 1'b1;
        tb = make_txn(1'b1, 1'b0, 24'h000020, 16'h0);
        drive(tb);
        @(negedge mem_clk);
        rst = 1'b0;
        wait_ack(100, got);
        b_req = 1'b0;
        n_total++;
        if (got !== 1'b1 || {a_ack, b_ack, b_rdata} !== {2'b01, tb.data})
            $display("FAIL rm_b_only: got %b ack %b b_rdata %h required 1 01 %h", got, {a_ack, b_ack}, b_rdata, tb.data);
        else n_pass++;
        wait_idle();
    endtask

`ifdef PSRAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        txn_t t;
        int   hi;
        bit   got;
        drv_hang = 1'b1;
        t = make_txn(1'b0, 1'b0, 24'h000040, 16'h0);
        drive(t);
        hi = 0; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge mem_clk);
            if (read_sw) hi++;
            if (a_ack || b_ack) begin got = 1'b1; break; end
        end
        a_req = 1'b0;
        drv_hang = 1'b0;
        n_total++;
        if (got !== 1'b1 || hi !== TO) $display("FAIL to_len: ack %b strobe cycles %0d required 1 %0d", got, hi, TO);
        else n_pass++;
        n_total++;
        if ({a_ack, a_rdata, err} !== {1'b1, 16'hDEAD, 1'b1})
            $display("FAIL to_result: ack %b rdata %h err %b required 1 dead 1", a_ack, a_rdata, err);
        else n_pass++;
        wait_idle();
        t = make_txn(1'b0, 1'b0, 24'h000020, 16'h0);
        drive(t);
        wait_ack(100, got);
        a_req = 1'b0;
        n_total++;
        if ({got, a_rdata, err} !== {1'b1, t.data, 1'b1})
            $display("FAIL to_sticky: got %b rdata %h err %b required 1 %h 1", got, a_rdata, err, t.data);
        else n_pass++;
        wait_idle();
    endtask
`else
    task automatic test_err_off();
        n_total++;
        if (err !== 1'b0) $display("FAIL err_off: err %b required 0", err);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_qpi_gate();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid();
`ifdef PSRAM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_err_off();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the `psram` top.
- Shares the single QPI PSRAM between requester A (UART command path) and requester B (secondary client, e.g. capture/logger).
- Converts per-port request/ack handshakes into the level-held `read_sw`/`write_sw` protocol. Enforces round-robin fairness and the CE-high gap between transactions.
- Blocks all traffic until PSRAM initialisation has completed (`qpi_on` high).

Parameters:
- `GAP_CYCLES`, 4, idle `mem_clk` cycles forced between consecutive PSRAM transactions (tCPH margin); range 1..15.
- `TIMEOUT_CYCLES`, 255, watchdog limit in `mem_clk` cycles for one transaction; used only with the optional feature.

Ports:
- `mem_clk` input 1: PSRAM domain clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `qpi_on` input 1: PSRAM initialisation complete; the arbiter grants nothing while low.
- `a_req` input 1: port A request, held until `a_ack`.
- `a_we` input 1: port A, 1 = write, 0 = read; stable while `a_req` is high.
- `a_addr` input 24: port A word address.
- `a_wdata` input 16: port A write data.
- `a_ack` output 1: one-cycle pulse; port A transaction finished.
- `a_rdata` output 16: port A read data; valid when `a_ack` pulses and the access was a read.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: identical to the A signals, for port B.
- `read_sw` output 1: to `psram`; level-held for the whole read.
- `write_sw` output 1: to `psram`; level-held for the whole write.
- `address` output 24: to `psram`.
- `data_in` output 16: to `psram`.
- `data_out` input 16: from `psram`; captured on `psram_done`.
- `psram_done` input 1: one-cycle pulse from the driver; transaction complete.
- `busy` output 1: high from grant until the end of GAP.
- `err` output 1: sticky watchdog error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: `read_sw`=0, `write_sw`=0, `address`=0, `data_in`=0, `a_ack`=`b_ack`=0, `a_rdata`=`b_rdata`=0, `busy`=0, `err`=0. FSM state = IDLE, last_grant = B (so A wins the first tie).
- FSM states:
  - IDLE: if `qpi_on` and any request, pick a winner. Register `address`/`data_in`/we from the winner and go to ISSUE. `busy` is 1 from the next cycle.
  - ISSUE, 1 cycle: assert `read_sw` or `write_sw` (never both) and go to WAIT.
  - WAIT: hold the strobe, `address` and `data_in` stable. On `psram_done`:
    - deassert the strobe;
    - capture `data_out` into the winner's rdata (reads only; writes leave rdata unchanged);
    - pulse the winner's ack in the same cycle;
    - load the gap counter and go to GAP.
  - GAP: count `GAP_CYCLES` cycles with both strobes low, then go to IDLE.
- Arbitration is round-robin: on simultaneous A and B requests the port not granted last wins. A single requester wins regardless of history. last_grant updates at grant.
- Minimum latency from `req` rising (in IDLE) to `ack` is 3 cycles plus the driver time. Back-to-back throughput is 1 transaction per (driver time + 3 + `GAP_CYCLES`) cycles.
- A requester dropping `req` before `ack` is a protocol violation. The arbiter completes the PSRAM transaction anyway and still pulses ack.
- `psram_done` arriving in IDLE, ISSUE or GAP is ignored.
- `qpi_on` falling mid-transaction: the current transaction finishes normally; no new grant until it rises again.
- `rst` mid-transaction drops the strobes next edge. The driver's CE recovery is the driver's responsibility.
- Address width is 24 bits with no wrap logic; addresses pass straight through.

Optional Feature:
- Macro `PSRAM_ARB_TIMEOUT_EN`.
- With the macro:
  - a counter runs in WAIT; reaching `TIMEOUT_CYCLES` without `psram_done` drops the strobe;
  - the winner's ack pulses with rdata = 16'hDEAD;
  - `err` sets (sticky until `rst`) and the FSM goes to GAP.
- Without the macro: WAIT holds indefinitely, `err` is constant 0, and no counter logic is present.

Decomposition:
- Shared package `psram_pkg`:
  - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, GAP=3);
  - `PSRAM_ADDR_W`=24, `PSRAM_DATA_W`=16;
  - the error fill constant 16'hDEAD;
  - command opcodes shared with the driver.
- Natural sub-module `rr_arb2`: combinational 2-way round-robin pick plus the last_grant register. The FSM stays in `psram_arbiter`.

Test Plan:
- `qpi_on`=0 with `a_req`=1 for 50 cycles → no strobe, no ack. Raise `qpi_on` → `read_sw` asserts 2 cycles later.
- A write, `addr`=24'h000123, `wdata`=16'hBEEF; driver model pulses done after 12 cycles → `write_sw` high for 13 cycles, `address`/`data_in` stable, `a_ack` 1 cycle, then 4 gap cycles.
- A read of the same address, model returns 16'hBEEF → `a_rdata`=16'hBEEF on the `a_ack` cycle; `b_rdata` unchanged.
- A and B requesting continuously for 6 transactions → grant order A,B,A,B,A,B; never both strobes high; gap ≥ 4 between them.
- `rst` asserted during WAIT → next cycle strobes 0, `busy` 0, no ack. After release, a pending `b_req` is granted first only if `a_req` is low.
- With `PSRAM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20, model never pulses done → strobe drops at cycle 20, `a_ack` pulses, `a_rdata`=16'hDEAD, `err`=1 and stays set.
